// File: rtl/lattice_sweep_ctrl.sv
// rtl/lattice_sweep_ctrl.sv - one-sweep raster sequencer for the LBM streaming datapath
// Optional LATTICE_PINGPONG_EN adds bank_sel_out for ping-pong BRAM bank selection.
module lattice_sweep_ctrl #(
  parameter int HPIXELS   = 205,
  parameter int VPIXELS   = 154,
  parameter int LATENCY   = 3,
  parameter int HOR_SIZE  = $clog2(HPIXELS),
  parameter int VERT_SIZE = $clog2(VPIXELS),
  parameter int CNT_SIZE  = $clog2(HPIXELS*VPIXELS+1)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic                 stall_in,
  input  logic                 abort_in,
  output logic [HOR_SIZE-1:0]  hor_out,
  output logic [VERT_SIZE-1:0] vert_out,
  output logic                 rd_valid_out,
  output logic                 wr_en_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [CNT_SIZE-1:0]  cells_done_out
`ifdef LATTICE_PINGPONG_EN
  ,
  output logic                 bank_sel_out
`endif
);

  localparam logic [HOR_SIZE-1:0]  HOR_MAX  = HOR_SIZE'(HPIXELS-1);
  localparam logic [VERT_SIZE-1:0] VERT_MAX = VERT_SIZE'(VPIXELS-1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [HOR_SIZE-1:0]    hor_d;
  logic [VERT_SIZE-1:0]   vert_d;
  logic                   rd_valid_d;
  logic                   wr_en_d;
  logic                   busy_d;
  logic                   done_d;
  logic [CNT_SIZE-1:0]    cnt_d;
  // pipe_q[i] holds rd_valid_out from i+1 cycles ago; wr_en_out is the final stage
  logic [LATENCY-2:0]     pipe_q, pipe_d;
  logic                   last_cell;

  assign last_cell = (hor_out == HOR_MAX) && (vert_out == VERT_MAX);

  always_comb begin
    state_d    = state_q;
    hor_d      = hor_out;
    vert_d     = vert_out;
    rd_valid_d = 1'b0;
    pipe_d     = '0;
    pipe_d[0]  = rd_valid_out;
    for (int i = 1; i < LATENCY-1; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    wr_en_d = pipe_q[LATENCY-2];
    cnt_d   = wr_en_d ? cells_done_out + CNT_SIZE'(1) : cells_done_out;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d    = S_SWEEP;
          hor_d      = '0;
          vert_d     = '0;
          rd_valid_d = 1'b1;
          cnt_d      = '0;
        end
      end
      S_SWEEP: begin
        // Coordinates only reach the last cell when it is issued, so leave regardless of stall
        if (last_cell) begin
          state_d = S_DRAIN;
        end else if (!stall_in) begin
          rd_valid_d = 1'b1;
          if (hor_out == HOR_MAX) begin
            hor_d  = '0;
            vert_d = vert_out + VERT_SIZE'(1);
          end else begin
            hor_d = hor_out + HOR_SIZE'(1);
          end
        end
      end
      S_DRAIN: begin
        if (pipe_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_in) begin
      state_d    = S_IDLE;
      hor_d      = '0;
      vert_d     = '0;
      rd_valid_d = 1'b0;
      pipe_d     = '0;
      wr_en_d    = 1'b0;
      cnt_d      = cells_done_out;
    end

    busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q        <= S_IDLE;
      hor_out        <= '0;
      vert_out       <= '0;
      rd_valid_out   <= 1'b0;
      pipe_q         <= '0;
      wr_en_out      <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      cells_done_out <= '0;
    end else begin
      state_q        <= state_d;
      hor_out        <= hor_d;
      vert_out       <= vert_d;
      rd_valid_out   <= rd_valid_d;
      pipe_q         <= pipe_d;
      wr_en_out      <= wr_en_d;
      busy_out       <= busy_d;
      done_out       <= done_d;
      cells_done_out <= cnt_d;
    end
  end

`ifdef LATTICE_PINGPONG_EN
  // Flip the bank as DONE is entered so the next sweep reads what this one wrote
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      bank_sel_out <= 1'b0;
    end else if (state_d == S_DONE) begin
      bank_sel_out <= ~bank_sel_out;
    end
  end
`endif

endmodule

// File: tb/tb_lattice_sweep_ctrl.sv
// tb/tb_lattice_sweep_ctrl.sv - directed table-driven bench for lattice_sweep_ctrl
// Set LATTICE_PINGPONG_EN to also exercise bank_sel_out.
module tb_lattice_sweep_ctrl;
  localparam int HP  = 4;
  localparam int VP  = 3;
  localparam int LAT = 3;
  localparam int HS  = $clog2(HP);
  localparam int VS  = $clog2(VP);
  localparam int CS  = $clog2(HP*VP+1);

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          start_in;
  logic          stall_in;
  logic          abort_in;
  logic [HS-1:0] hor_out;
  logic [VS-1:0] vert_out;
  logic          rd_valid_out;
  logic          wr_en_out;
  logic          busy_out;
  logic          done_out;
  logic [CS-1:0] cells_done_out;
`ifdef LATTICE_PINGPONG_EN
  logic          bank_sel_out;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  lattice_sweep_ctrl #(.HPIXELS(HP), .VPIXELS(VP), .LATENCY(LAT)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .start_in       (start_in),
    .stall_in       (stall_in),
    .abort_in       (abort_in),
    .hor_out        (hor_out),
    .vert_out       (vert_out),
    .rd_valid_out   (rd_valid_out),
    .wr_en_out      (wr_en_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .cells_done_out (cells_done_out)
`ifdef LATTICE_PINGPONG_EN
    ,
    .bank_sel_out   (bank_sel_out)
`endif
  );

  typedef struct {
    logic start;
    logic stall;
    logic abort;
    logic rdv;
    int   hor;
    int   vert;
    logic wr;
    logic busy;
    logic done;
    int   cells;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic rdv, int h, int v, logic wr, logic b, logic d, int c);
    vec_t r;
    r.start = st; r.stall = 1'b0; r.abort = 1'b0;
    r.rdv = rdv; r.hor = h; r.vert = v; r.wr = wr; r.busy = b; r.done = d; r.cells = c;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0; start_in = 1'b0; stall_in = 1'b0; abort_in = 1'b0;
    step();
    step();
    rst_n_in = 1'b1;
  endtask

  int n_rdv, n_done, done_cyc, stray;

  initial begin
    // Basic sweep, cycle by cycle
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 3));
    tbl.push_back(mk(0, 1, 2, 1, 1, 1, 0, 4));
    tbl.push_back(mk(0, 1, 3, 1, 1, 1, 0, 5));
    tbl.push_back(mk(0, 1, 0, 2, 1, 1, 0, 6));
    tbl.push_back(mk(0, 1, 1, 2, 1, 1, 0, 7));
    tbl.push_back(mk(0, 1, 2, 2, 1, 1, 0, 8));
    tbl.push_back(mk(0, 1, 3, 2, 1, 1, 0, 9));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 10));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 11));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 12));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 12));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 12));

    do_reset();
    chk("reset_hor", hor_out, 0);
    chk("reset_vert", vert_out, 0);
`ifdef LATTICE_PINGPONG_EN
    chk("reset_bank", bank_sel_out, 0);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      start_in = tbl[i].start; stall_in = tbl[i].stall; abort_in = tbl[i].abort;
      chk($sformatf("basic_rdv[%0d]", i), rd_valid_out, tbl[i].rdv);
      if (tbl[i].rdv) begin
        chk($sformatf("basic_hor[%0d]", i), hor_out, tbl[i].hor);
        chk($sformatf("basic_vert[%0d]", i), vert_out, tbl[i].vert);
      end
      chk($sformatf("basic_wr[%0d]", i), wr_en_out, tbl[i].wr);
      chk($sformatf("basic_busy[%0d]", i), busy_out, tbl[i].busy);
      chk($sformatf("basic_done[%0d]", i), done_out, tbl[i].done);
      chk($sformatf("basic_cells[%0d]", i), cells_done_out, tbl[i].cells);
      step();
    end

    // Stall cycles 3..5
    do_reset();
    n_rdv = 0; n_done = 0; done_cyc = -1;
    for (int c = 0; c < 26; c++) begin
      start_in = (c == 0);
      stall_in = (c >= 3 && c <= 5);
      if (rd_valid_out) n_rdv++;
      if (done_out) begin n_done++; done_cyc = c; end
      if (c >= 4 && c <= 6) begin
        chk($sformatf("stall_gap_rdv[%0d]", c), rd_valid_out, 0);
        chk($sformatf("stall_hold_hor[%0d]", c), hor_out, 2);
        chk($sformatf("stall_hold_vert[%0d]", c), vert_out, 0);
      end
      if (c == 7) begin
        chk("stall_resume_rdv", rd_valid_out, 1);
        chk("stall_resume_hor", hor_out, 3);
      end
      step();
    end
    stall_in = 1'b0;
    chk("stall_rdv_total", n_rdv, 12);
    chk("stall_done_count", n_done, 1);
    chk("stall_done_cycle", done_cyc, 19);
    chk("stall_cells", cells_done_out, 12);

    // Abort at cycle 7, restart at cycle 10
    do_reset();
    n_done = 0; done_cyc = -1;
    for (int c = 0; c < 45 && done_cyc < 0; c++) begin
      start_in = (c == 0 || c == 10);
      abort_in = (c == 7);
      if (c == 8) begin
        chk("abort_rdv", rd_valid_out, 0);
        chk("abort_wr", wr_en_out, 0);
        chk("abort_busy", busy_out, 0);
        chk("abort_cells_hold", cells_done_out, 4);
      end
      if (c >= 8 && c <= 10) chk($sformatf("abort_wr_quiet[%0d]", c), wr_en_out, 0);
      if (c == 11) begin
        chk("restart_rdv", rd_valid_out, 1);
        chk("restart_hor", hor_out, 0);
        chk("restart_vert", vert_out, 0);
      end
      if (done_out) begin n_done++; done_cyc = c; end
      step();
    end
    start_in = 1'b0; abort_in = 1'b0;
    chk("restart_done_cycle", done_cyc, 26);
    chk("restart_done_count", n_done, 1);
    chk("restart_cells", cells_done_out, 12);

    // Start held high: one sweep, then a second starting from IDLE at cycle 17
    do_reset();
    n_done = 0; done_cyc = -1;
    for (int c = 0; c <= 20; c++) begin
      start_in = 1'b1;
      if (done_out) begin n_done++; done_cyc = c; end
      if (c == 17) begin
        chk("held_idle_rdv", rd_valid_out, 0);
        chk("held_idle_busy", busy_out, 0);
      end
      if (c == 18) begin
        chk("held_second_rdv", rd_valid_out, 1);
        chk("held_second_hor", hor_out, 0);
        chk("held_second_vert", vert_out, 0);
      end
      step();
    end
    chk("held_done_count", n_done, 1);
    chk("held_done_cycle", done_cyc, 16);
    start_in = 1'b0; abort_in = 1'b1;
    step();
    abort_in = 1'b0;

    // start and abort together in IDLE
    do_reset();
    start_in = 1'b1; abort_in = 1'b1;
    step();
    start_in = 1'b0; abort_in = 1'b0;
    chk("simul_rdv", rd_valid_out, 0);
    chk("simul_busy", busy_out, 0);
    step();
    chk("simul_rdv_late", rd_valid_out, 0);
    chk("simul_busy_late", busy_out, 0);

    // Reset mid-sweep at cycle 6
    do_reset();
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      start_in = (c == 0);
      rst_n_in = (c != 6);
      if (c == 7) begin
        chk("midrst_rdv", rd_valid_out, 0);
        chk("midrst_wr", wr_en_out, 0);
        chk("midrst_busy", busy_out, 0);
        chk("midrst_done", done_out, 0);
        chk("midrst_cells", cells_done_out, 0);
        chk("midrst_hor", hor_out, 0);
        chk("midrst_vert", vert_out, 0);
      end
      if (c >= 7 && (wr_en_out || rd_valid_out || done_out)) stray++;
      step();
    end
    rst_n_in = 1'b1;
    chk("midrst_stray", stray, 0);

`ifdef LATTICE_PINGPONG_EN
    do_reset();
    for (int s = 0; s < 3; s++) begin
      done_cyc = -1;
      for (int c = 0; c < 40 && done_cyc < 0; c++) begin
        start_in = (c == 0);
        abort_in = (s == 2 && c == 5);
        if (done_out) begin
          done_cyc = c;
          chk($sformatf("bank_at_done[%0d]", s), bank_sel_out, (s == 0) ? 1 : 0);
        end
        if (s == 2 && c == 10) done_cyc = c;
        step();
      end
      start_in = 1'b0; abort_in = 1'b0;
    end
    chk("bank_after_abort", bank_sel_out, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
